// File: rtl/axis_bram_adapter_s_axis_writer.sv
// ---------------------------------------------------------------------------
// axis_bram_adapter_s_axis_writer
//   AXI4-Stream slave that captures one packet into a BRAM write port, one
//   word per address starting at 0. When TLAST is accepted, the block raises
//   FRAME_DONE with the word count and an overflow flag. It then waits in HOLD
//   until user logic acknowledges with FRAME_ACK.
//
// Ports
//   S_AXIS_ACLK    in   sole clock, rising edge
//   S_AXIS_ARESET  in   synchronous reset, active-high
//   S_AXIS_TVALID  in   upstream beat valid
//   S_AXIS_TDATA   in   beat payload
//   S_AXIS_TSTRB   in   byte qualifiers, forwarded as byte write enables
//   S_AXIS_TLAST   in   last beat of packet
//   S_AXIS_TREADY  out  high while receiving
//   BRAM_EN        out  BRAM port enable (write cycle)
//   BRAM_WE        out  BRAM byte write enables
//   BRAM_ADDR      out  BRAM word address
//   BRAM_DIN       out  BRAM write data
//   FRAME_DONE     out  packet captured, held until FRAME_ACK
//   FRAME_LEN      out  words written for this packet
//   FRAME_OVF      out  packet exceeded C_BRAM_DEPTH, excess beats dropped
//   FRAME_ACK      in   frame consumed, re-arms the block
//
// state | meaning
// ------+-----------------------------------------------------------------
// RECV  | accepting beats, writing them to BRAM (or dropping them once full)
// HOLD  | frame reported, stream stalled until FRAME_ACK
// ---------------------------------------------------------------------------
module axis_bram_adapter_s_axis_writer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_BRAM_ADDR_WIDTH    = 10,
    parameter int C_BRAM_DEPTH         = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic                              BRAM_EN,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] BRAM_WE,
    output logic [C_BRAM_ADDR_WIDTH-1:0]      BRAM_ADDR,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   BRAM_DIN,
    output logic                              FRAME_DONE,
    output logic [C_BRAM_ADDR_WIDTH:0]        FRAME_LEN,
    output logic                              FRAME_OVF,
    input  logic                              FRAME_ACK
);

    localparam int AW = C_BRAM_ADDR_WIDTH;
    localparam int BW = C_S_AXIS_TDATA_WIDTH / 8;

    // One extra bit so the count can hold C_BRAM_DEPTH itself.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(C_BRAM_DEPTH);

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    logic [AW:0]   count;
    logic          ovf;
    logic          has_room;
    logic          beat;

    assign S_AXIS_TREADY = (state == RECV);
    assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign has_room      = (count < DEPTH_C);

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state      <= RECV;
            count      <= '0;
            ovf        <= 1'b0;
            BRAM_EN    <= 1'b0;
            BRAM_WE    <= '0;
            BRAM_ADDR  <= '0;
            BRAM_DIN   <= '0;
            FRAME_DONE <= 1'b0;
            FRAME_LEN  <= '0;
            FRAME_OVF  <= 1'b0;
        end else begin
            // Write strobes are single-cycle; address/data hold their last values.
            BRAM_EN <= 1'b0;
            BRAM_WE <= '0;
            case (state)
                RECV: begin
                    if (beat) begin
                        if (has_room) begin
                            BRAM_EN   <= 1'b1;
                            BRAM_WE   <= S_AXIS_TSTRB;
                            BRAM_ADDR <= count[AW-1:0];
                            BRAM_DIN  <= S_AXIS_TDATA;
                            count     <= count + 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (S_AXIS_TLAST) begin
                            // Report using the post-beat count and overflow state.
                            state      <= HOLD;
                            FRAME_DONE <= 1'b1;
                            FRAME_LEN  <= count + {{AW{1'b0}}, has_room};
                            FRAME_OVF  <= ovf | ~has_room;
                        end
                    end
                end
                HOLD: begin
                    if (FRAME_ACK) begin
                        state      <= RECV;
                        count      <= '0;
                        ovf        <= 1'b0;
                        FRAME_DONE <= 1'b0;
                        FRAME_LEN  <= '0;
                        FRAME_OVF  <= 1'b0;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_adapter_s_axis_writer.sv
module tb_axis_bram_adapter_s_axis_writer;

    localparam int W     = 32;
    localparam int BW    = W / 8;
    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic [BW-1:0] tstrb;
    logic          tlast;
    logic          tready;
    logic          bram_en;
    logic [BW-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_din;
    logic          frame_done;
    logic [AW:0]   frame_len;
    logic          frame_ovf;
    logic          frame_ack;

    int n_checks = 0;
    int n_fail   = 0;

    axis_bram_adapter_s_axis_writer #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .C_BRAM_ADDR_WIDTH    (AW),
        .C_BRAM_DEPTH         (DEPTH)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .BRAM_EN       (bram_en),
        .BRAM_WE       (bram_we),
        .BRAM_ADDR     (bram_addr),
        .BRAM_DIN      (bram_din),
        .FRAME_DONE    (frame_done),
        .FRAME_LEN     (frame_len),
        .FRAME_OVF     (frame_ovf),
        .FRAME_ACK     (frame_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one beat at the current negedge, step to the next negedge, check the write.
    task automatic beat(input logic [W-1:0] d, input logic [BW-1:0] s, input logic l,
                        input logic exp_en, input int exp_addr);
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        @(negedge clk);
        check("beat_en", bram_en, exp_en);
        if (exp_en) begin
            check("beat_we",   bram_we,   s);
            check("beat_addr", bram_addr, exp_addr);
            check("beat_din",  bram_din,  d);
        end else begin
            check("drop_we", bram_we, 0);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic done, input int len, input logic ovf);
        check({tag, "_done"},  frame_done, done);
        check({tag, "_len"},   frame_len,  len);
        check({tag, "_ovf"},   frame_ovf,  ovf);
        check({tag, "_tready"}, tready,    !done);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_frame("ack", 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = '0;
        tstrb     = '0;
        tlast     = 1'b0;
        frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_en",   bram_en,   0);
        check("rst_we",   bram_we,   0);
        check("rst_addr", bram_addr, 0);
        check("rst_din",  bram_din,  0);
        check_frame("rst", 1'b0, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", tready, 1);

        // 1: four back-to-back beats
        for (int i = 0; i < 4; i++)
            beat(32'hA0 + i, 4'hF, i == 3, 1'b1, i);
        check_frame("t1", 1'b1, 4, 1'b0);

        // 2: stall in HOLD, then acknowledge
        for (int i = 0; i < 5; i++) begin
            tvalid = 1'b1;
            tdata  = 32'hDEAD0000 + i;
            tstrb  = 4'hF;
            @(negedge clk);
            check("hold_tready", tready,  0);
            check("hold_en",     bram_en, 0);
            check_frame("hold", 1'b1, 4, 1'b0);
        end
        tvalid = 1'b0;
        ack();
        check("idle_addr_held", bram_addr, 3);
        check("idle_din_held",  bram_din,  32'hA3);

        // ack while receiving has no effect
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_frame("ack_in_recv", 1'b0, 0, 1'b0);
        check("ack_in_recv_en", bram_en, 0);

        // 3: eleven beats into an eight-word buffer
        for (int i = 0; i < 11; i++) begin
            beat(32'hB000 + i, 4'hF, i == 10, i < DEPTH, i);
            if (i < 10) check("ovf_tready", tready, 1);
        end
        check_frame("t3", 1'b1, 8, 1'b1);
        ack();

        // 4: byte strobes, gaps, zero-strobe beat
        beat(32'h11223344, 4'b0101, 1'b0, 1'b1, 0);
        repeat (2) begin
            @(negedge clk);
            check("gap_en",   bram_en,   0);
            check("gap_we",   bram_we,   0);
            check("gap_addr", bram_addr, 0);
        end
        beat(32'h55667788, 4'b0000, 1'b0, 1'b1, 1);
        beat(32'h99AABBCC, 4'hF,    1'b1, 1'b1, 2);
        check_frame("t4", 1'b1, 3, 1'b0);
        ack();

        // 5: reset mid-packet, then a fresh two-beat frame
        for (int i = 0; i < 3; i++)
            beat(32'hC0 + i, 4'hF, 1'b0, 1'b1, i);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_en",   bram_en,   0);
        check("mid_rst_addr", bram_addr, 0);
        check("mid_rst_din",  bram_din,  0);
        check_frame("mid_rst", 1'b0, 0, 1'b0);
        beat(32'hC3, 4'hF, 1'b0, 1'b1, 0);
        beat(32'hC4, 4'hF, 1'b1, 1'b1, 1);
        check_frame("t5", 1'b1, 2, 1'b0);
        ack();

        // single-beat packet
        beat(32'hD0, 4'hF, 1'b1, 1'b1, 0);
        check_frame("single", 1'b1, 1, 1'b0);
        ack();

        // exactly DEPTH beats: full but not overflowed
        for (int i = 0; i < DEPTH; i++)
            beat(32'hE0 + i, 4'hF, i == DEPTH - 1, 1'b1, i);
        check_frame("full", 1'b1, DEPTH, 1'b0);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
